// File: rtl/lfsr_encrypt.sv
// rtl/lfsr_encrypt.sv - 64-byte frame encryptor: preamble plus memory bytes XORed with a 6-bit LFSR stream
// Optional macro ENC_PARITY_EN: wdata[7] carries even parity of wdata[6:0].
module lfsr_encrypt (
    input  logic       clk,
    input  logic       init_n,
    input  logic       start,
    input  logic [2:0] ptrn_sel,
    input  logic [5:0] lfsr_init,
    input  logic [3:0] pre_len,
    input  logic [7:0] rdata,
    output logic [7:0] raddr,
    output logic [7:0] waddr,
    output logic       wr_en,
    output logic [7:0] wdata,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [5:0] k_q, k_d;
    logic [5:0] lfsr_q, lfsr_d;
    logic [5:0] taps_q, taps_d;
    logic [3:0] plen_q, plen_d;
    logic       wr_en_q, wr_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] raddr_q, raddr_d;
    logic [7:0] waddr_q, waddr_d;
    logic [7:0] src, xored;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lfsr_d  = lfsr_q;
        taps_d  = taps_q;
        plen_d  = plen_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                case (ptrn_sel)
                    3'd1:    taps_d = 6'h2D;
                    3'd2:    taps_d = 6'h30;
                    3'd3:    taps_d = 6'h33;
                    3'd4:    taps_d = 6'h36;
                    3'd5:    taps_d = 6'h39;
                    default: taps_d = 6'h21;
                endcase
                // An all-zero seed would lock the LFSR, so it is replaced by 1.
                lfsr_d  = (lfsr_init == 6'd0) ? 6'h01 : lfsr_init;
                if (pre_len < 4'd7)       plen_d = 4'd7;
                else if (pre_len > 4'd12) plen_d = 4'd12;
                else                      plen_d = pre_len;
                k_d     = 6'd0;
                state_d = RUN;
            end
            RUN: begin
                lfsr_d = {lfsr_q[4:0], ^(lfsr_q & taps_q)};
                k_d    = k_q + 6'd1;
                if (k_q == 6'd63) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        wr_en_d = (state_d == RUN);
        busy_d  = (state_d == LOAD) || (state_d == RUN);
        done_d  = (state_d == DONE);
        waddr_d = wr_en_d ? {2'b01, k_d} : 8'd0;
        raddr_d = (wr_en_d && (k_d >= {2'b00, plen_d})) ?
                  ({2'b00, k_d} - {4'b0000, plen_d}) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q <= IDLE;
            k_q     <= 6'd0;
            lfsr_q  <= 6'd0;
            taps_q  <= 6'd0;
            plen_q  <= 4'd0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            raddr_q <= 8'd0;
            waddr_q <= 8'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lfsr_q  <= lfsr_d;
            taps_q  <= taps_d;
            plen_q  <= plen_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
        end
    end

    // rdata answers raddr within the same cycle, so wdata stays combinational.
    always_comb begin
        src   = (k_q < {2'b00, plen_q}) ? 8'h5F : rdata;
        xored = src ^ {2'b00, lfsr_q};
`ifdef ENC_PARITY_EN
        wdata = wr_en_q ? {^xored[6:0], xored[6:0]} : 8'd0;
`else
        wdata = wr_en_q ? xored : 8'd0;
`endif
    end

    assign wr_en = wr_en_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign raddr = raddr_q;
    assign waddr = waddr_q;
endmodule
